// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   LSU_OP_LD / LSU_OP_ST : the only legal opcodes; anything else completes with value 0.
//   lsu_state_t           : execution FSM states.
//   lsu_entry_t           : one queued memory op {rob_idx, opcode, addr, wdata}.
// Entry field widths follow LSU_DATA_W / LSU_ROB_IDX_W; the top-level width
// parameters default to these and must stay equal to them.
package lsu_pkg;

  localparam int LSU_DATA_W    = 16;
  localparam int LSU_ROB_IDX_W = 4;

  localparam logic [3:0] LSU_OP_LD = 4'd8;
  localparam logic [3:0] LSU_OP_ST = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RESP,
    BCAST,
    DRAIN
  } lsu_state_t;

  typedef struct packed {
    logic [LSU_ROB_IDX_W-1:0] rob_idx;
    logic [3:0]               opcode;
    logic [LSU_DATA_W-1:0]    addr;
    logic [LSU_DATA_W-1:0]    wdata;
  } lsu_entry_t;

  function automatic logic lsu_op_legal(input logic [3:0] op);
    return (op == LSU_OP_LD) || (op == LSU_OP_ST);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of every non-clock signal of the load/store unit.
//   issue : in_valid, in_rob_idx, in_opcode, in_a_value, in_b_value -> lsu_full
//   ctrl  : rob_head (store commit gate), flush
//   mem   : mem_req_{valid,we,addr,wdata} / mem_req_ready, mem_resp_{valid,rdata}
//   cdb   : cdb_valid, cdb_rob_idx, cdb_value
// modport slave  : the LSU itself.
// modport master : the surrounding core / memory / testbench.
interface lsu_if #(
  parameter int DATA_W    = 16,
  parameter int ROB_IDX_W = 4
) ();

  logic                 in_valid;
  logic [ROB_IDX_W-1:0] in_rob_idx;
  logic [3:0]           in_opcode;
  logic [DATA_W-1:0]    in_a_value;
  logic [DATA_W-1:0]    in_b_value;
  logic                 lsu_full;

  logic [ROB_IDX_W-1:0] rob_head;
  logic                 flush;

  logic                 mem_req_valid;
  logic                 mem_req_ready;
  logic                 mem_req_we;
  logic [DATA_W-1:0]    mem_req_addr;
  logic [DATA_W-1:0]    mem_req_wdata;
  logic                 mem_resp_valid;
  logic [DATA_W-1:0]    mem_resp_rdata;

  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob_idx;
  logic [DATA_W-1:0]    cdb_value;

  modport slave (
    input  in_valid, in_rob_idx, in_opcode, in_a_value, in_b_value,
    input  rob_head, flush,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output lsu_full,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output cdb_valid, cdb_rob_idx, cdb_value
  );

  modport master (
    output in_valid, in_rob_idx, in_opcode, in_a_value, in_b_value,
    output rob_head, flush,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  lsu_full,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  cdb_valid, cdb_rob_idx, cdb_value
  );

endinterface

// File: rtl/lsu_queue.sv
// Circular issue-order FIFO of lsu_entry_t.
//   clk, rst   : clock, async active-high reset
//   push       : write push_entry at tail (ignored when full)
//   pop        : retire head (ignored when empty)
//   clear      : empty the queue, pointers back to 0 (wins over push/pop)
//   head       : entry at head (undefined while empty)
//   count      : occupancy 0..DEPTH
//   full       : count == DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module lsu_queue
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  lsu_entry_t                   push_entry,
  input  logic                         pop,
  input  logic                         clear,
  output lsu_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  lsu_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign head    = mem_q[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads a slot before it is written.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store functional unit (CDB slot 1).
//   clk, rst : clock, async active-high reset
//   bus      : lsu_if.slave -- issue port, rob_head/flush, memory
//              valid/ready request + in-order response, CDB broadcast.
// Ops are queued in issue order and executed one at a time from the head:
// IDLE -> REQ -> RESP -> BCAST for loads/stores, IDLE -> BCAST for illegal
// opcodes. Stores wait in IDLE until the ROB head reaches them. A flush that
// catches a request already accepted by memory parks in DRAIN to swallow the
// orphan response before the next op may use the memory channel.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int DATA_W    = LSU_DATA_W,
  parameter int ROB_IDX_W = LSU_ROB_IDX_W
) (
  input  logic clk,
  input  logic rst,
  lsu_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  lsu_state_t           state_q, state_d;
  lsu_entry_t           in_entry, head;
  logic [CNT_W-1:0]     count;
  logic                 q_full, q_push, q_pop, q_empty;
  logic [DATA_W-1:0]    rdata_q;
  logic [ROB_IDX_W-1:0] head_idx;
  logic                 head_ld, head_st, head_legal;

  assign in_entry = '{rob_idx: bus.in_rob_idx, opcode: bus.in_opcode,
                      addr: bus.in_a_value, wdata: bus.in_b_value};

  // Flush beats a same-cycle issue; a same-cycle dequeue never admits an issue.
  assign q_push = bus.in_valid && !q_full && !bus.flush;
  assign q_pop  = (state_q == BCAST) && !bus.flush;

  lsu_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_entry (in_entry),
    .pop        (q_pop),
    .clear      (bus.flush),
    .head       (head),
    .count      (count),
    .full       (q_full)
  );

  assign q_empty    = (count == '0);
  assign head_idx   = head.rob_idx;
  assign head_ld    = (head.opcode == LSU_OP_LD);
  assign head_st    = (head.opcode == LSU_OP_ST);
  assign head_legal = lsu_op_legal(head.opcode);
  assign bus.lsu_full = q_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == RESP && bus.mem_resp_valid && head_ld)
        rdata_q <= bus.mem_resp_rdata;
    end
  end

  always_comb begin
    state_d           = state_q;
    bus.mem_req_valid = 1'b0;
    bus.mem_req_we    = 1'b0;
    bus.mem_req_addr  = '0;
    bus.mem_req_wdata = '0;
    bus.cdb_valid     = 1'b0;
    bus.cdb_rob_idx   = '0;
    bus.cdb_value     = '0;

    case (state_q)
      IDLE: begin
        if (!bus.flush && !q_empty) begin
          if (!head_legal)                   state_d = BCAST;
          else if (head_ld)                  state_d = REQ;
          else if (bus.rob_head == head_idx) state_d = REQ;
        end
      end
      REQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = head_st;
        bus.mem_req_addr  = head.addr;
        bus.mem_req_wdata = head.wdata;
        // A flush withdraws the request unless memory takes it this very cycle,
        // in which case its response is still owed to us.
        if (bus.flush)              state_d = bus.mem_req_ready ? DRAIN : IDLE;
        else if (bus.mem_req_ready) state_d = RESP;
      end
      RESP: begin
        // A response landing in the flush cycle settles the debt; no drain.
        if (bus.mem_resp_valid) state_d = bus.flush ? IDLE : BCAST;
        else if (bus.flush)     state_d = DRAIN;
      end
      BCAST: begin
        bus.cdb_valid = !bus.flush;
        if (!bus.flush) begin
          bus.cdb_rob_idx = head_idx;
          bus.cdb_value   = head_ld ? rdata_q : '0;
        end
        state_d = IDLE;
      end
      DRAIN: begin
        if (bus.mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_if #(.DATA_W(16), .ROB_IDX_W(4)) bus ();

  load_store_unit #(.DEPTH(DEPTH), .DATA_W(16), .ROB_IDX_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
  endtask

  // ---------------- environment: memory + reference model ----------------
  typedef struct {
    logic [3:0]  idx;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] ld_val;
    bit          requested;
    bit          gate_seen;
  } op_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  logic [15:0] mem [256];
  op_t         exp_ops[$];   // ops issued and not yet broadcast, program order
  resp_t       pend[$];      // accepted requests awaiting a response
  int          resp_lat = 0;
  int          cyc = 0;

  function automatic bit legal_op(input logic [3:0] op);
    return op == 4'd8 || op == 4'd9;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: one response per accepted request, in order,
  // resp_lat extra cycles after the minimum of one cycle.
  initial begin
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = pend[0].data;
        void'(pend.pop_front());
      end else begin
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_rdata = 16'($urandom);
      end
    end
  end

  // Compare process: every cycle, mid-cycle.
  int          size0;
  op_t         e;
  bit          prev_hold = 0;
  logic [33:0] prev_vec;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ctl_zero", {bus.lsu_full, bus.mem_req_valid, bus.mem_req_we, bus.cdb_valid, bus.cdb_rob_idx}, 0);
      chk("rst_data_zero", {bus.mem_req_addr | bus.mem_req_wdata, bus.cdb_value}, 0);
      exp_ops.delete();
      prev_hold = 0;
    end else begin
      size0 = exp_ops.size();
      chk("lsu_full", bus.lsu_full, size0 == DEPTH);
      if (size0 > 0 && exp_ops[0].op == LSU_OP_ST && bus.rob_head == exp_ops[0].idx)
        exp_ops[0].gate_seen = 1;
      if (prev_hold)
        chk("req_hold", {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata}, prev_vec);
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (bus.mem_req_we) mem[bus.mem_req_addr[7:0]] = bus.mem_req_wdata;
        pend.push_back('{due: cyc + 1 + resp_lat, data: mem[bus.mem_req_addr[7:0]]});
        chk("req_has_op", size0 > 0, 1);
        if (size0 > 0) begin
          e = exp_ops[0];
          chk("req_first_time", e.requested, 0);
          chk("req_legal_op", legal_op(e.op), 1);
          chk("req_we", bus.mem_req_we, e.op == LSU_OP_ST);
          chk("req_addr", bus.mem_req_addr, e.a);
          if (e.op == LSU_OP_ST) begin
            chk("req_wdata", bus.mem_req_wdata, e.b);
            chk("req_store_gate", e.gate_seen, 1);
          end
          exp_ops[0].requested = 1;
          exp_ops[0].ld_val    = (e.op == LSU_OP_LD) ? mem[e.a[7:0]] : 16'h0;
        end
      end
      prev_hold = bus.mem_req_valid && !bus.mem_req_ready && !bus.flush;
      prev_vec  = {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr, bus.mem_req_wdata};
      if (bus.cdb_valid) begin
        chk("cdb_not_in_flush", bus.flush, 0);
        chk("cdb_has_op", size0 > 0, 1);
        if (size0 > 0) begin
          e = exp_ops[0];
          chk("cdb_idx", bus.cdb_rob_idx, e.idx);
          chk("cdb_mem_done", e.requested, legal_op(e.op));
          chk("cdb_value", bus.cdb_value, (e.op == LSU_OP_LD) ? e.ld_val : 16'h0);
          void'(exp_ops.pop_front());
        end
      end
      if (bus.flush) exp_ops.delete();
      else if (bus.in_valid && size0 < DEPTH)
        exp_ops.push_back('{idx: bus.in_rob_idx, op: bus.in_opcode, a: bus.in_a_value,
                            b: bus.in_b_value, ld_val: 16'h0, requested: 0, gate_seen: 0});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] idx, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b);
    bus.in_valid   = 1'b1;
    bus.in_rob_idx = idx;
    bus.in_opcode  = op;
    bus.in_a_value = a;
    bus.in_b_value = b;
    tick();
    bus.in_valid   = 1'b0;
  endtask

  task automatic wait_cdb(input int maxc, output bit found,
                          output logic [3:0] idx, output logic [15:0] val);
    found = 0; idx = '0; val = '0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (bus.cdb_valid) begin
        found = 1; idx = bus.cdb_rob_idx; val = bus.cdb_value;
        break;
      end
    end
    tick();
  endtask

  initial begin
    #400000;
    n_chk++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // ---------------- main sequence ----------------
  bit          found;
  logic [3:0]  gidx;
  logic [15:0] gval;
  int          highs;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[8'h10] = 16'hBEEF;
    mem[8'h30] = 16'h5A5A;
    bus.in_valid = 0; bus.in_rob_idx = 0; bus.in_opcode = 0;
    bus.in_a_value = 0; bus.in_b_value = 0;
    bus.rob_head = 0; bus.flush = 0; bus.mem_req_ready = 1;
    rst = 1'b1;
    repeat (3) tick();
    chk("reset_full", bus.lsu_full, 0);
    chk("reset_req_valid", bus.mem_req_valid, 0);
    chk("reset_cdb_valid", bus.cdb_valid, 0);
    rst = 1'b0;
    tick();

    // Load: issue in N, request in N+2, broadcast in N+4 only.
    issue(4'd3, LSU_OP_LD, 16'h0010, 16'h0);
    @(negedge clk);  // N+1
    chk("ld_n1_req", bus.mem_req_valid, 0);
    chk("ld_n1_cdb", bus.cdb_valid, 0);
    @(negedge clk);  // N+2
    chk("ld_n2_req", {bus.mem_req_valid, bus.mem_req_we, bus.mem_req_addr}, {1'b1, 1'b0, 16'h0010});
    @(negedge clk);  // N+3
    chk("ld_n3_cdb", bus.cdb_valid, 0);
    @(negedge clk);  // N+4
    chk("ld_n4_cdb", {bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_value}, {1'b1, 4'd3, 16'hBEEF});
    @(negedge clk);  // N+5
    chk("ld_n5_cdb", bus.cdb_valid, 0);
    tick();

    // Illegal opcode: no memory traffic, broadcast of value 0 in N+2.
    issue(4'd9, 4'd0, 16'h0022, 16'h0);
    @(negedge clk);
    chk("ill_n1", {bus.cdb_valid, bus.mem_req_valid}, 0);
    @(negedge clk);
    chk("ill_n2", {bus.cdb_valid, bus.cdb_rob_idx, bus.cdb_value, bus.mem_req_valid}, {1'b1, 4'd9, 16'h0, 1'b0});
    @(negedge clk);
    chk("ill_n3", {bus.cdb_valid, bus.mem_req_valid}, 0);
    tick();

    // Store gate: held until rob_head matches.
    bus.rob_head = 4'd2;
    issue(4'd5, LSU_OP_ST, 16'h0020, 16'h1234);
    highs = 0;
    repeat (20) begin @(negedge clk); if (bus.mem_req_valid) highs++; end
    chk("st_gated", highs, 0);
    tick();
    bus.rob_head = 4'd5;
    wait_cdb(12, found, gidx, gval);
    chk("st_cdb_found", found, 1);
    chk("st_cdb", {gidx, gval}, {4'd5, 16'h0});
    chk("st_mem_written", mem[8'h20], 16'h1234);
    bus.rob_head = 4'd0;

    // Backpressure: queue fills, fifth issue dropped, in-order drain.
    bus.mem_req_ready = 0;
    for (int i = 0; i < 4; i++) issue(4'(i), LSU_OP_LD, 16'h0050 + 16'(i), 16'h0);
    @(negedge clk);
    chk("bp_full", bus.lsu_full, 1);
    tick();
    issue(4'd12, LSU_OP_LD, 16'h0060, 16'h0);
    repeat (3) tick();
    chk("bp_req_addr", {bus.mem_req_valid, bus.mem_req_addr}, {1'b1, 16'h0050});
    bus.mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      wait_cdb(12, found, gidx, gval);
      chk("bp_found", found, 1);
      chk("bp_order", {gidx, gval}, {4'(i), 16'h1050 + 16'(i)});
    end
    wait_cdb(10, found, gidx, gval);
    chk("bp_dropped_issue", found, 0);

    // Flush during RESP with two queued; late response must be discarded.
    resp_lat = 5;
    issue(4'd7, LSU_OP_LD, 16'h0010, 16'h0);
    issue(4'd10, LSU_OP_LD, 16'h0012, 16'h0);
    issue(4'd11, LSU_OP_LD, 16'h0013, 16'h0);
    bus.flush = 1;
    @(negedge clk);
    chk("fl_cdb_masked", bus.cdb_valid, 0);
    tick();
    bus.flush = 0;
    resp_lat = 0;
    chk("fl_not_full", bus.lsu_full, 0);
    issue(4'd8, LSU_OP_LD, 16'h0030, 16'h0);
    wait_cdb(20, found, gidx, gval);
    chk("fl_next_found", found, 1);
    chk("fl_next_cdb", {gidx, gval}, {4'd8, 16'h5A5A});

    // Reset mid-RESP with a full queue: outputs drop without a clock edge.
    resp_lat = 6;
    for (int i = 1; i < 5; i++) issue(4'(i), LSU_OP_LD, 16'h0040 + 16'(i), 16'h0);
    @(negedge clk);
    chk("rs_full_before", bus.lsu_full, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rs_async_ctl", {bus.lsu_full, bus.mem_req_valid, bus.cdb_valid}, 0);
    chk("rs_async_data", {bus.mem_req_addr, bus.cdb_value}, 0);
    repeat (2) tick();
    rst = 1'b0;
    resp_lat = 0;
    for (int k = 0; k < 20 && pend.size() > 0; k++) tick();
    chk("rs_late_resp_seen", pend.size(), 0);
    tick();
    chk("rs_quiet", {bus.cdb_valid, bus.mem_req_valid, bus.lsu_full}, 0);
    issue(4'd6, LSU_OP_LD, 16'h0011, 16'h0);
    wait_cdb(10, found, gidx, gval);
    chk("rs_fresh_found", found, 1);
    chk("rs_fresh_cdb", {gidx, gval}, {4'd6, 16'h1011});

    // Randomized traffic against the model.
    for (int c = 0; c < 600; c++) begin
      int r;
      r = int'($urandom % 10);
      bus.in_valid   = ($urandom % 3) == 0;
      bus.in_rob_idx = 4'($urandom);
      bus.in_opcode  = (r < 5) ? LSU_OP_LD : (r < 9) ? LSU_OP_ST : ((r % 2) ? 4'd3 : 4'd15);
      bus.in_a_value = 16'($urandom % 32);
      bus.in_b_value = 16'($urandom);
      bus.mem_req_ready = ($urandom % 4) != 0;
      resp_lat = int'($urandom % 3);
      bus.flush = ($urandom % 50) == 0;
      if (exp_ops.size() > 0 && ($urandom % 3) != 0) bus.rob_head = exp_ops[0].idx;
      else bus.rob_head = 4'($urandom);
      tick();
    end
    bus.in_valid = 0; bus.flush = 0; bus.mem_req_ready = 1;
    for (int k = 0; k < 300 && exp_ops.size() > 0; k++) begin
      bus.rob_head = exp_ops[0].idx;
      tick();
    end
    chk("rand_drained", exp_ops.size(), 0);
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
